// File: rtl/urv_writeback_ahb.sv
// urv_writeback_ahb: writeback stage with AHB-Lite data-phase tracking.
// Selects the register-file write value, aligns load data, registers HWDATA,
// and tracks wait states, bus errors, timeouts and misaligned accesses.
module urv_writeback_ahb #(
  parameter int TIMEOUT     = 0,
  parameter int REG_LOAD    = 0,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic        x_valid_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [2:0]  x_rd_source_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [31:0] rf_rd_value_o,
  output logic [4:0]  rf_rd_o,
  output logic        rf_rd_write_o,
  output logic        w_fault_o,
  output logic [1:0]  w_fault_cause_o,
  output logic [31:0] w_fault_addr_o
);

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam bit TIMEOUT_EN  = (TIMEOUT > 0);
  localparam bit REG_LOAD_EN = (REG_LOAD != 0);
  localparam bit ALIGN_EN    = (ALIGN_CHECK != 0);

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [2:0] RD_SOURCE_SHIFTER  = 3'b001;
  localparam logic [2:0] RD_SOURCE_MULTIPLY = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR,
    S_LDWB
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   load_reg;
  logic [31:0]   load_aligned;
  logic [31:0]   load_value;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          misaligned;
  logic          mem;
  logic          done;
  logic          discard;
  logic          good_done;
  logic          go_ldwb;
  logic          load_wb_now;
  logic          mis_fault;
  logic          bus_err;
  logic          timeout_hit;
  logic          wr;

  assign rf_rd_o = x_rd_i;

  // Extract and extend the addressed lane of HRDATA, and flag misaligned sizes.
  always_comb begin
    load_aligned = HRDATA;
    load_byte    = 8'h00;
    misaligned   = 1'b0;
    case (x_dm_addr_i[1:0])
      2'b00:   load_byte = HRDATA[7:0];
      2'b01:   load_byte = HRDATA[15:8];
      2'b10:   load_byte = HRDATA[23:16];
      default: load_byte = HRDATA[31:24];
    endcase
    load_half = x_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];
    case (x_fun_i)
      LDST_B:  load_aligned = {{24{load_byte[7]}}, load_byte};
      LDST_BU: load_aligned = {24'h000000, load_byte};
      LDST_H:  load_aligned = {{16{load_half[15]}}, load_half};
      LDST_HU: load_aligned = {16'h0000, load_half};
      default: load_aligned = HRDATA;
    endcase
    if (ALIGN_EN) begin
      case (x_fun_i)
        LDST_H, LDST_HU: misaligned = x_dm_addr_i[0];
        LDST_L:          misaligned = |x_dm_addr_i[1:0];
        default:         misaligned = 1'b0;
      endcase
    end
  end

  // Data-phase next state, stall request, fault triggers and writeback select.
  always_comb begin
    mem         = x_valid_i & (x_load_i | x_store_i);
    discard     = TIMEOUT_EN && (state == S_WAIT) && (wait_cnt == CNT_MAX);
    done        = 1'b0;
    bus_err     = 1'b0;
    timeout_hit = 1'b0;
    state_next  = state;
    case (state)
      S_IDLE: begin
        if (mem) begin
          if (HREADY)     done       = 1'b1;
          else if (HRESP) state_next = S_ERR;
          else            state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (HREADY && !HRESP) begin
          done = 1'b1;
        end else if (HREADY && HRESP) begin
          bus_err    = 1'b1;
          state_next = S_IDLE;
        end else if (HRESP) begin
          state_next = S_ERR;
        end else begin
          timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);
        end
      end
      S_ERR: begin
        if (HREADY && HRESP) begin
          bus_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_LDWB:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Timed-out transfers finish on the bus but leave no trace in the core.
    good_done   = done & ~discard;
    go_ldwb     = REG_LOAD_EN && good_done && x_load_i && !misaligned;
    load_wb_now = !REG_LOAD_EN && good_done && x_load_i && !misaligned;
    mis_fault   = good_done & misaligned;
    if (done) state_next = go_ldwb ? S_LDWB : S_IDLE;

    case (state)
      S_IDLE:  w_stall_req_o = mem & (~HREADY | go_ldwb);
      S_WAIT:  w_stall_req_o = ~done | go_ldwb;
      S_ERR:   w_stall_req_o = 1'b1;
      default: w_stall_req_o = 1'b0;
    endcase

    if (state == S_LDWB)              wr = x_valid_i;
    else if (state != S_IDLE || mem)  wr = load_wb_now & x_valid_i;
    else                              wr = x_rd_write_i & x_valid_i;
    rf_rd_write_o = wr & ~w_stall_i;

    load_value = REG_LOAD_EN ? load_reg : load_aligned;
    if (x_load_i || state == S_LDWB)               rf_rd_value_o = load_value;
    else if (x_rd_source_i == RD_SOURCE_SHIFTER)   rf_rd_value_o = x_shifter_rd_value_i;
    else if (x_rd_source_i == RD_SOURCE_MULTIPLY)  rf_rd_value_o = x_multiply_rd_value_i;
    else                                           rf_rd_value_o = x_rd_value_i;
  end

  // State register and saturating wait counter, cleared whenever not waiting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Write data follows the address phase of a write accepted by the bus.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                HWDATA <= 32'h0;
    else if (HWRITE && HREADY) HWDATA <= x_HWDATA;
  end

  // Hold the aligned load value for the deferred writeback cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       load_reg <= 32'h0;
    else if (go_ldwb) load_reg <= load_aligned;
  end

  // One-cycle fault pulse; cause and address only change when a fault fires.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_fault_o       <= 1'b0;
      w_fault_cause_o <= 2'b00;
      w_fault_addr_o  <= 32'h0;
    end else begin
      w_fault_o <= bus_err | timeout_hit | mis_fault;
      if (bus_err) begin
        w_fault_cause_o <= 2'b01;
        w_fault_addr_o  <= x_dm_addr_i;
      end else if (timeout_hit) begin
        w_fault_cause_o <= 2'b10;
        w_fault_addr_o  <= x_dm_addr_i;
      end else if (mis_fault) begin
        w_fault_cause_o <= 2'b11;
        w_fault_addr_o  <= x_dm_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_urv_writeback_ahb.sv
// Testbench for urv_writeback_ahb: vector table, multi-cycle sequences and
// randomized single-cycle traffic against a behavioural model.
module tb_urv_writeback_ahb;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_L  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] SRC_ALU   = 3'b000;
  localparam logic [2:0] SRC_SHIFT = 3'b001;
  localparam logic [2:0] SRC_MUL   = 3'b010;
  localparam int TMO = 4;

  typedef struct {
    logic        valid, load, store, wstall, hready, hresp, hwrite, rdw;
    logic [2:0]  fun, src;
    logic [4:0]  rd;
    logic [31:0] addr, hrdata, rdv, shv, mulv, hwd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] ev;
    logic        ew;
    logic        ef;
    logic [1:0]  ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_stall;
  logic [2:0]  x_fun, x_src;
  logic        x_load, x_store, x_valid, x_rdw;
  logic [31:0] x_addr, x_rdv, x_shv, x_mulv, x_hwdata;
  logic [4:0]  x_rd;
  logic [31:0] hrdata;
  logic        hready, hresp, hwrite;

  logic        stall_req, rf_write, fault;
  logic [31:0] hwdata_out, rf_value, fault_addr;
  logic [4:0]  rf_rd;
  logic [1:0]  fault_cause;

  logic        rl_stall_req, rl_rf_write, rl_fault;
  logic [31:0] rl_hwdata_out, rl_rf_value, rl_fault_addr;
  logic [4:0]  rl_rf_rd;
  logic [1:0]  rl_fault_cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  urv_writeback_ahb #(.TIMEOUT(TMO), .REG_LOAD(0), .ALIGN_CHECK(1)) dut (
    .clk_i(clk), .rst_i(rst_n), .w_stall_i(w_stall), .w_stall_req_o(stall_req),
    .x_fun_i(x_fun), .x_load_i(x_load), .x_store_i(x_store), .x_valid_i(x_valid),
    .x_dm_addr_i(x_addr), .x_rd_i(x_rd), .x_rd_value_i(x_rdv),
    .x_shifter_rd_value_i(x_shv), .x_multiply_rd_value_i(x_mulv),
    .x_rd_source_i(x_src), .x_rd_write_i(x_rdw), .x_HWDATA(x_hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HWRITE(hwrite),
    .HWDATA(hwdata_out), .rf_rd_value_o(rf_value), .rf_rd_o(rf_rd),
    .rf_rd_write_o(rf_write), .w_fault_o(fault), .w_fault_cause_o(fault_cause),
    .w_fault_addr_o(fault_addr)
  );

  urv_writeback_ahb #(.TIMEOUT(TMO), .REG_LOAD(1), .ALIGN_CHECK(1)) dut_rl (
    .clk_i(clk), .rst_i(rst_n), .w_stall_i(w_stall), .w_stall_req_o(rl_stall_req),
    .x_fun_i(x_fun), .x_load_i(x_load), .x_store_i(x_store), .x_valid_i(x_valid),
    .x_dm_addr_i(x_addr), .x_rd_i(x_rd), .x_rd_value_i(x_rdv),
    .x_shifter_rd_value_i(x_shv), .x_multiply_rd_value_i(x_mulv),
    .x_rd_source_i(x_src), .x_rd_write_i(x_rdw), .x_HWDATA(x_hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HWRITE(hwrite),
    .HWDATA(rl_hwdata_out), .rf_rd_value_o(rl_rf_value), .rf_rd_o(rl_rf_rd),
    .rf_rd_write_o(rl_rf_write), .w_fault_o(rl_fault), .w_fault_cause_o(rl_fault_cause),
    .w_fault_addr_o(rl_fault_addr)
  );

  // Compare a 32-bit value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Compare a single bit and record the outcome.
  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Drive every DUT input from one stimulus record.
  task automatic applyStimulus(input stim_t s);
    x_valid  = s.valid;  x_load  = s.load;   x_store = s.store;
    w_stall  = s.wstall; hready  = s.hready; hresp   = s.hresp;
    hwrite   = s.hwrite; x_rdw   = s.rdw;    x_fun   = s.fun;
    x_src    = s.src;    x_rd    = s.rd;     x_addr  = s.addr;
    hrdata   = s.hrdata; x_rdv   = s.rdv;    x_shv   = s.shv;
    x_mulv   = s.mulv;   x_hwdata = s.hwd;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{valid: 1'b0, load: 1'b0, store: 1'b0, wstall: 1'b0, hready: 1'b1,
          hresp: 1'b0, hwrite: 1'b0, rdw: 1'b0, fun: F_L, src: SRC_ALU, rd: 5'd0,
          addr: 32'h0, hrdata: 32'h0, rdv: 32'h0, shv: 32'h0, mulv: 32'h0, hwd: 32'h0};
    return s;
  endfunction

  // A valid, single-cycle memory (or plain) operation with fixed side values.
  function automatic stim_t op(logic [2:0] fun, logic ld, logic st, logic [31:0] addr, logic [31:0] data);
    stim_t s;
    s = idle();
    s.valid = 1'b1; s.load = ld; s.store = st; s.hwrite = st; s.rdw = 1'b1;
    s.fun = fun; s.rd = 5'd7; s.addr = addr; s.hrdata = data;
    s.rdv = 32'h1111_1111; s.shv = 32'h2222_2222; s.mulv = 32'h3333_3333;
    s.hwd = 32'hCAFE_0000 ^ addr;
    return s;
  endfunction

  function automatic vec_t v(stim_t s, logic [31:0] ev, logic ew, logic ef, logic [1:0] ec);
    vec_t r;
    r.s = s; r.ev = ev; r.ew = ew; r.ef = ef; r.ec = ec;
    return r;
  endfunction

  function automatic int size_of(logic [2:0] fun);
    if (fun == F_B || fun == F_BU) return 1;
    if (fun == F_H || fun == F_HU) return 2;
    return 4;
  endfunction

  // Reference load value: shift the naturally aligned chunk down, then extend.
  function automatic logic [31:0] model_load(logic [2:0] fun, logic [31:0] addr, logic [31:0] data);
    int sz, off;
    longint unsigned wide, span, raw;
    sz = size_of(fun);
    if (sz == 4) return data;
    off  = int'(addr % 4) - int'(addr % sz);
    wide = {32'h0, data};
    span = 64'd1 << (8 * sz);
    raw  = (wide >> (8 * off)) % span;
    if ((fun == F_B || fun == F_H) && raw >= span / 2) raw = raw - span;
    return raw[31:0];
  endfunction

  function automatic logic model_mis(logic [2:0] fun, logic [31:0] addr);
    return (addr % size_of(fun)) != 0;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(idle());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t        vecs[$];
  logic [2:0]  funs[5];
  stim_t       s;
  logic [31:0] m_hwdata, m_faddr, m_value;
  logic [1:0]  m_cause;
  logic        m_write, m_fault;

  initial begin
    funs[0] = F_B; funs[1] = F_H; funs[2] = F_L; funs[3] = F_BU; funs[4] = F_HU;

    // Vector table: single-cycle accesses completing with HREADY high.
    vecs.push_back(v(op(F_L,  1, 0, 32'h100, 32'h8000_1234), 32'h8000_1234, 1, 0, 2'd0));
    vecs.push_back(v(op(F_H,  1, 0, 32'h102, 32'h8001_7FFF), 32'hFFFF_8001, 1, 0, 2'd0));
    vecs.push_back(v(op(F_BU, 1, 0, 32'h103, 32'hA500_0000), 32'h0000_00A5, 1, 0, 2'd0));
    vecs.push_back(v(op(F_B,  1, 0, 32'h101, 32'h1234_8056), 32'hFFFF_FF80, 1, 0, 2'd0));
    vecs.push_back(v(op(F_HU, 1, 0, 32'h100, 32'h1234_F00D), 32'h0000_F00D, 1, 0, 2'd0));
    vecs.push_back(v(op(F_H,  1, 0, 32'h100, 32'h1234_F00D), 32'hFFFF_F00D, 1, 0, 2'd0));
    vecs.push_back(v(op(F_B,  1, 0, 32'h103, 32'h7F00_0000), 32'h0000_007F, 1, 0, 2'd0));
    vecs.push_back(v(op(F_L,  1, 0, 32'h101, 32'hDEAD_BEEF), 32'hDEAD_BEEF, 0, 1, 2'd3));
    vecs.push_back(v(op(F_HU, 1, 0, 32'h103, 32'hABCD_0123), 32'h0000_ABCD, 0, 1, 2'd3));
    s = op(F_L, 1, 0, 32'h108, 32'h0BAD_F00D); s.wstall = 1'b1;
    vecs.push_back(v(s, 32'h0BAD_F00D, 0, 0, 2'd0));
    vecs.push_back(v(op(F_L,  0, 1, 32'h104, 32'h0), 32'h1111_1111, 0, 0, 2'd0));
    vecs.push_back(v(op(F_H,  0, 1, 32'h106, 32'h0), 32'h1111_1111, 0, 0, 2'd0));
    vecs.push_back(v(op(F_L,  0, 1, 32'h106, 32'h0), 32'h1111_1111, 0, 1, 2'd3));
    vecs.push_back(v(op(F_B,  0, 1, 32'h103, 32'h0), 32'h1111_1111, 0, 0, 2'd0));
    s = op(F_L, 0, 0, 32'h101, 32'h0); s.src = SRC_SHIFT;
    vecs.push_back(v(s, 32'h2222_2222, 1, 0, 2'd0));
    s = op(F_L, 0, 0, 32'h101, 32'h0); s.src = SRC_MUL; s.rdw = 1'b0;
    vecs.push_back(v(s, 32'h3333_3333, 0, 0, 2'd0));
    s = op(F_L, 0, 0, 32'h0, 32'h0); s.valid = 1'b0;
    vecs.push_back(v(s, 32'h1111_1111, 0, 0, 2'd0));

    // Reset state, both instances.
    doReset();
    #2;
    checkOutput("reset HWDATA", hwdata_out, 32'h0);
    checkBit("reset fault", fault, 1'b0);
    checkOutput("reset cause", 32'(fault_cause), 32'h0);
    checkOutput("reset fault addr", fault_addr, 32'h0);
    checkBit("reset stall", stall_req, 1'b0);
    checkBit("reset rf write", rf_write, 1'b0);
    checkOutput("rl reset HWDATA", rl_hwdata_out, 32'h0);
    checkBit("rl reset fault", rl_fault, 1'b0);
    checkOutput("rl reset cause", 32'(rl_fault_cause), 32'h0);
    checkOutput("rl reset fault addr", rl_fault_addr, 32'h0);
    @(posedge clk); #1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      #2;
      checkOutput($sformatf("vec%0d value", i), rf_value, vecs[i].ev);
      checkBit($sformatf("vec%0d write", i), rf_write, vecs[i].ew);
      checkBit($sformatf("vec%0d stall", i), stall_req, 1'b0);
      checkOutput($sformatf("vec%0d rd", i), 32'(rf_rd), 32'(vecs[i].s.rd));
      @(posedge clk); #1;
      checkBit($sformatf("vec%0d fault", i), fault, vecs[i].ef);
      if (vecs[i].ef) begin
        checkOutput($sformatf("vec%0d cause", i), 32'(fault_cause), 32'(vecs[i].ec));
        checkOutput($sformatf("vec%0d fault addr", i), fault_addr, vecs[i].s.addr);
      end
      if (vecs[i].s.hwrite)
        checkOutput($sformatf("vec%0d HWDATA", i), hwdata_out, vecs[i].s.hwd);
    end

    // LW with three HREADY-low cycles, then completion.
    doReset();
    s = op(F_L, 1, 0, 32'h200, 32'h0);
    s.hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(s);
      #2;
      checkBit($sformatf("wait%0d stall", c), stall_req, 1'b1);
      checkBit($sformatf("wait%0d write", c), rf_write, 1'b0);
      @(posedge clk); #1;
    end
    s.hready = 1'b1; s.hrdata = 32'h5A5A_C3C3;
    applyStimulus(s);
    #2;
    checkBit("wait done stall", stall_req, 1'b0);
    checkBit("wait done write", rf_write, 1'b1);
    checkOutput("wait done value", rf_value, 32'h5A5A_C3C3);
    @(posedge clk); #1;
    checkBit("wait done fault", fault, 1'b0);

    // Store hit by a two-cycle error response.
    doReset();
    s = op(F_L, 0, 1, 32'h344, 32'h0);
    s.hready = 1'b0; s.hresp = 1'b1;
    applyStimulus(s);
    #2;
    checkBit("err first stall", stall_req, 1'b1);
    @(posedge clk); #1;
    s.hready = 1'b1;
    applyStimulus(s);
    #2;
    checkBit("err second stall", stall_req, 1'b1);
    checkBit("err write", rf_write, 1'b0);
    @(posedge clk); #1;
    checkBit("err fault", fault, 1'b1);
    checkOutput("err cause", 32'(fault_cause), 32'h1);
    checkOutput("err fault addr", fault_addr, 32'h344);
    applyStimulus(idle());
    @(posedge clk); #1;
    checkBit("err pulse ends", fault, 1'b0);

    // Timeout: HREADY low for ten cycles, pulse after the TMO-th wait cycle.
    doReset();
    s = op(F_L, 1, 0, 32'h480, 32'h0);
    s.hready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(s);
      #2;
      checkBit($sformatf("tmo%0d stall", c), stall_req, 1'b1);
      checkBit($sformatf("tmo%0d write", c), rf_write, 1'b0);
      @(posedge clk); #1;
      checkBit($sformatf("tmo%0d fault", c), fault, c == TMO);
      if (c == TMO) begin
        checkOutput("tmo cause", 32'(fault_cause), 32'h2);
        checkOutput("tmo fault addr", fault_addr, 32'h480);
      end
    end
    s.hready = 1'b1; s.hrdata = 32'h7777_7777;
    applyStimulus(s);
    #2;
    checkBit("tmo release stall", stall_req, 1'b0);
    checkBit("tmo discard write", rf_write, 1'b0);
    @(posedge clk); #1;
    checkBit("tmo no second fault", fault, 1'b0);

    // Registered load: one extra stall cycle, write in the following cycle.
    doReset();
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? op(F_L, 1, 0, 32'h500, 32'h1357_2468) : op(F_B, 1, 0, 32'h502, 32'h0080_0000);
      m_value = model_load(s.fun, s.addr, s.hrdata);
      applyStimulus(s);
      #2;
      checkBit($sformatf("rl%0d capture stall", k), rl_stall_req, 1'b1);
      checkBit($sformatf("rl%0d capture write", k), rl_rf_write, 1'b0);
      @(posedge clk); #1;
      s.hrdata = 32'hFFFF_0000;
      applyStimulus(s);
      #2;
      checkBit($sformatf("rl%0d ldwb stall", k), rl_stall_req, 1'b0);
      checkBit($sformatf("rl%0d ldwb write", k), rl_rf_write, 1'b1);
      checkOutput($sformatf("rl%0d ldwb value", k), rl_rf_value, m_value);
      checkOutput($sformatf("rl%0d rd", k), 32'(rl_rf_rd), 32'(s.rd));
      @(posedge clk); #1;
      applyStimulus(idle());
      #2;
      checkBit($sformatf("rl%0d after write", k), rl_rf_write, 1'b0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a wait aborts the transfer silently.
    doReset();
    s = op(F_L, 1, 0, 32'h600, 32'h0);
    s.hready = 1'b0;
    repeat (2) begin
      applyStimulus(s);
      @(posedge clk); #1;
    end
    s = idle(); s.hready = 1'b0; s.hresp = 1'b1;
    applyStimulus(s);
    #1 rst_n = 1'b0;
    #1;
    checkBit("mid reset stall", stall_req, 1'b0);
    checkBit("mid reset fault", fault, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    checkBit("post reset stall", stall_req, 1'b0);
    checkBit("post reset write", rf_write, 1'b0);
    @(posedge clk); #1;
    checkBit("post reset fault", fault, 1'b0);

    // Randomized single-cycle traffic against the behavioural model.
    doReset();
    m_hwdata = 32'h0; m_faddr = 32'h0; m_cause = 2'd0;
    for (int n = 0; n < 300; n++) begin
      int kind;
      s = idle();
      kind     = $urandom_range(0, 2);
      s.valid  = ($urandom_range(0, 7) != 0);
      s.load   = (kind == 1);
      s.store  = (kind == 2);
      s.wstall = ($urandom_range(0, 5) == 0);
      s.hwrite = 1'($urandom_range(0, 1));
      s.rdw    = 1'($urandom_range(0, 1));
      s.fun    = funs[$urandom_range(0, 4)];
      s.src    = 3'($urandom_range(0, 7));
      s.rd     = 5'($urandom_range(0, 31));
      s.addr   = $urandom;
      s.hrdata = $urandom;
      s.rdv    = $urandom;
      s.shv    = $urandom;
      s.mulv   = $urandom;
      s.hwd    = $urandom;

      if (s.load)                 m_value = model_load(s.fun, s.addr, s.hrdata);
      else if (s.src == SRC_SHIFT) m_value = s.shv;
      else if (s.src == SRC_MUL)   m_value = s.mulv;
      else                         m_value = s.rdv;
      m_fault = s.valid && (s.load || s.store) && model_mis(s.fun, s.addr);
      if (!s.valid || s.wstall || s.store) m_write = 1'b0;
      else if (s.load)                     m_write = !model_mis(s.fun, s.addr);
      else                                 m_write = s.rdw;
      if (m_fault) begin
        m_faddr = s.addr;
        m_cause = 2'd3;
      end
      if (s.hwrite) m_hwdata = s.hwd;

      applyStimulus(s);
      #2;
      checkOutput($sformatf("rnd%0d value", n), rf_value, m_value);
      checkBit($sformatf("rnd%0d write", n), rf_write, m_write);
      checkBit($sformatf("rnd%0d stall", n), stall_req, 1'b0);
      @(posedge clk); #1;
      checkBit($sformatf("rnd%0d fault", n), fault, m_fault);
      checkOutput($sformatf("rnd%0d cause", n), 32'(fault_cause), 32'(m_cause));
      checkOutput($sformatf("rnd%0d fault addr", n), fault_addr, m_faddr);
      checkOutput($sformatf("rnd%0d HWDATA", n), hwdata_out, m_hwdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/urv_writeback_ahb.md
Name: urv_writeback_ahb

Overview:
Parametrised successor to the current writeback stage. Selects the register-file write value, aligns and sign-extends AHB-Lite load data, and registers HWDATA. Adds a data-phase state machine with a wait-state timeout, HRESP error handling, an optional misalignment check and optional load-data registering. Sits between the execute stage (x_*) and the register file/AHB master port, and reports faults to the trap logic.

Parameters:
TIMEOUT, 0, max HREADY-low wait cycles before a timeout fault; 0 disables the check.
REG_LOAD, 0, 1 captures load data in a register and writes it back one cycle after completion.
ALIGN_CHECK, 1, 1 flags misaligned LH/LHU/LW/SH/SW accesses.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
w_stall_i  in  1  pipeline stall; forces rf_rd_write_o=0
w_stall_req_o  out  1  stall request to the pipeline
x_fun_i  in  3  LDST_* size/sign code
x_load_i / x_store_i  in  1  memory op type
x_valid_i  in  1  execute-stage result valid
x_dm_addr_i  in  32  data address
x_rd_i  in  5  destination register
x_rd_value_i / x_shifter_rd_value_i / x_multiply_rd_value_i  in  32  result sources
x_rd_source_i  in  3  RD_SOURCE_* select
x_rd_write_i  in  1  rd write enable
x_HWDATA  in  32  store data from execute
HRDATA  in  32  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response
HWRITE  in  1  AHB address-phase write
HWDATA  out  32  registered AHB write data
rf_rd_value_o  out  32  register-file write value
rf_rd_o  out  5  equals x_rd_i
rf_rd_write_o  out  1  register-file write enable
w_fault_o  out  1  one-cycle fault pulse
w_fault_cause_o  out  2  01 bus error, 10 timeout, 11 misaligned
w_fault_addr_o  out  32  x_dm_addr_i captured at fault

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, wait counter 0, HWDATA=0, w_fault_o=0, w_fault_cause_o=0, w_fault_addr_o=0, load register=0. Reset during any state aborts the transfer without a fault or rf write.
- mem = x_valid_i & (x_load_i | x_store_i).
- HWDATA <= x_HWDATA when HWRITE & HREADY.
- Load alignment: B/BU select the byte lane by addr[1:0]. H/HU select the halfword by addr[1]. L passes HRDATA through. Sign bits for H/B come from HRDATA (bits 15/31 for H).
- Value mux priority: load, then shifter, then multiply, then x_rd_value_i. When REG_LOAD=1, the load value comes from the load register.
- Misaligned (ALIGN_CHECK=1): H/HU with addr[0]=1; L with addr[1:0]!=0. B is never misaligned.
- States:
  - IDLE:
    - mem & HREADY: the access completes this cycle.
    - mem & !HREADY & !HRESP: go to WAIT; stall asserted combinationally this cycle.
    - mem & !HREADY & HRESP: go to ERR.
  - WAIT:
    - Stall asserted; counter increments each cycle.
    - HREADY & !HRESP: completion, return to IDLE.
    - !HREADY & HRESP: go to ERR.
    - Counter == TIMEOUT-1 (TIMEOUT>0): fault cause 10 pulses once. Stay in WAIT with stall held. Completion data is then discarded (no rf write, no further fault).
  - ERR: stall asserted. On HREADY & HRESP: fault cause 01 pulses once, no rf write, go to IDLE.
  - LDWB (REG_LOAD=1 only):
    - Entered on load completion, when the load register is captured.
    - Stall asserted for exactly one extra cycle; rf write happens in LDWB; then IDLE.
- Completion rules:
  - Load: rf_rd_write_o=x_valid_i, at completion (REG_LOAD=0) or in LDWB (REG_LOAD=1).
  - Store: no rf write.
  - Misaligned access: completes on the bus normally, rf write suppressed, fault cause 11 pulses at completion.
- Non-memory ops: rf_rd_write_o = x_rd_write_i & x_valid_i.
- w_stall_i=1 forces rf_rd_write_o=0. The FSM still advances; a load completing under w_stall_i is not written.
- Fault priority on the same cycle: bus error > timeout > misaligned. w_fault_addr_o updates only on a pulse.
- Counter width is clog2(TIMEOUT+1). The counter saturates and clears on IDLE.

Test Plan:
- LW addr 0x100, HREADY=1, HRDATA=0x8000_1234 -> same cycle: rf_rd_write_o=1, rf_rd_value_o=0x8000_1234, no stall.
- LH addr 0x102, HRDATA=0x8001_7FFF -> 0xFFFF_8001. LBU addr 0x103, HRDATA=0xA5000000 -> 0x0000_00A5.
- LW with HREADY low for 3 cycles, TIMEOUT=8 -> w_stall_req_o high for 3 cycles; rf write only on the 4th cycle.
- SW, HRESP=1 with HREADY=0, then HREADY=1 -> w_fault_o pulse, cause 01, w_fault_addr_o=x_dm_addr_i, no rf write.
- TIMEOUT=4, HREADY held low for 10 cycles -> fault cause 10 after the 4th wait cycle; stall held until HREADY; no rf write.
- LW addr 0x101, ALIGN_CHECK=1 -> cause 11, no rf write.
- REG_LOAD=1 LW -> one extra stall cycle, write in LDWB.
- Reset asserted mid-WAIT -> IDLE, no fault.
